// File: rtl/alu_pkg.sv
// Shared opcode encodings and default data width for the ALU issue path.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [3:0] OPCODE_LE  = 4'b0011;
    localparam logic [3:0] OPCODE_XOR = 4'b0100;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OPCODE_LE) || (op == OPCODE_XOR);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request storage for the ALU issue queue: circular buffer with wrapping pointers.
module alu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned EW    = 36
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [EW-1:0]              i_wdata,
    output logic [EW-1:0]              o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU requests, presents the head to an external LE/XOR ALU and
// registers its result behind a valid/ready output stage.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [3:0]                 in_opcode,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [3:0]                 alu_opcode,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned EW = 2 * WIDTH + 4;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_head;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_illegal;

    // Entry layout: {opcode, a, b}
    assign w_wdata = {in_opcode, in_a, in_b};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign w_empty  = (w_count == '0);
    assign in_ready = (w_count != CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && (!r_out_valid || out_ready);

    always_comb begin
        alu_opcode = '0;
        alu_a      = '0;
        alu_b      = '0;
        if (!w_empty) begin
            alu_opcode = w_head[EW-1 -: 4];
            alu_a      = w_head[2*WIDTH-1 -: WIDTH];
            alu_b      = w_head[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            if (is_legal_op(alu_opcode)) begin
                r_out_result  <= alu_result;
                r_out_illegal <= 1'b0;
            end else begin
                r_out_result  <= '0;
                r_out_illegal <= 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_illegal = r_out_illegal;
    assign count       = w_count;

endmodule
